// File: rtl/pulse_to_hold_if.sv
// pulse_to_hold_if: event/status bundle between an event source (master) and pulse_to_hold (slave)
// pulse, clear_overflow : master -> slave
// hold, busy, pending, overflow : slave -> master
interface pulse_to_hold_if #(parameter int PEND_WIDTH = 2);
  logic                  pulse;
  logic                  clear_overflow;
  logic                  hold;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
  logic                  overflow;
  modport master (output pulse, clear_overflow, input hold, busy, pending, overflow);
  modport slave (input pulse, clear_overflow, output hold, busy, pending, overflow);
endinterface

// File: rtl/pulse_to_hold.sv
// pulse_to_hold: stretches one-cycle event pulses into fixed-length hold levels separated by low gaps
// clock, reset : rising-edge clock, synchronous active-high reset
// bus.pulse, bus.clear_overflow : event strobe, overflow clear
// bus.hold, bus.busy, bus.pending, bus.overflow : held level, not-idle, queued events, sticky drop flag
// PULSE_TO_HOLD_RETRIGGER_EN : when defined, a pulse during a hold restarts it instead of queuing
module pulse_to_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_WIDTH   = 24,
  parameter int PEND_WIDTH  = 2
) (
  input logic              clock,
  input logic              reset,
  pulse_to_hold_if.slave   bus
);
`ifdef PULSE_TO_HOLD_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam logic [CNT_WIDTH-1:0]  HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [PEND_WIDTH:0]   PEND_MAX  = {1'b0, {PEND_WIDTH{1'b1}}};
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nx;
  logic [PEND_WIDTH:0]   pend_inc, pend_net;
  logic [PEND_WIDTH-1:0] pend_nx;
  logic                  queue, play, ovf_set, hold_nx, busy_nx;
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.hold     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.pending  <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bus.hold     <= hold_nx;
      bus.busy     <= busy_nx;
      bus.pending  <= pend_nx;
      bus.overflow <= ovf_set | (bus.overflow & ~bus.clear_overflow);
    end
  end
  // pending is computed one bit wider so increment and replay in the same
  // cycle cancel before saturation is judged
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - CNT_WIDTH'(1);
    play     = 1'b0;
    queue    = bus.pulse && (state == GAP || (state == HOLD && !RETRIG));
    pend_inc = {1'b0, bus.pending} + (PEND_WIDTH + 1)'(queue);
    case (state)
      IDLE: begin
        state_nx = bus.pulse ? HOLD : IDLE;
        cnt_nx   = bus.pulse ? HOLD_LOAD : cnt;
      end
      HOLD: begin
        if (RETRIG && bus.pulse) cnt_nx = HOLD_LOAD;
        else if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          play     = pend_inc != '0;
          state_nx = play ? HOLD : IDLE;
          cnt_nx   = play ? HOLD_LOAD : cnt;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    pend_net = pend_inc - (PEND_WIDTH + 1)'(play);
    ovf_set  = pend_net > PEND_MAX;
    pend_nx  = ovf_set ? PEND_MAX[PEND_WIDTH-1:0] : pend_net[PEND_WIDTH-1:0];
  end
  always_comb begin
    hold_nx = state_nx == HOLD;
    busy_nx = state_nx != IDLE;
  end
endmodule

// File: tb/tb_pulse_to_hold.sv
// tb_pulse_to_hold: table-driven cycle-by-cycle check of pulse_to_hold
module tb_pulse_to_hold;
  logic clock = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  pulse_to_hold_if #(.PEND_WIDTH(2)) bus ();
  pulse_to_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_WIDTH(24), .PEND_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    string       name;
    logic [63:0] pul, rst, clr;
    logic [63:0] hold, busy, ovf;
    int          pc0, pv0, pc1, pv1;
  } vec_t;
  vec_t v[6];
  int   nv;
  function automatic logic [63:0] rng(int a, int b);
    logic [63:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction
  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.pulse = 1'b0;
    bus.clear_overflow = 1'b0;
    nv = 0;
    v[nv++] = '{"single", rng(10,10), '0, '0, rng(11,14), rng(11,16), '0, 13, 0, 20, 0};
    v[nv++] = '{"last_gap", rng(10,10) | rng(16,16), '0, '0, rng(11,14) | rng(17,20), rng(11,22), '0, 17, 0, 18, 0};
    v[nv++] = '{"reset_mid", rng(10,10) | rng(12,12), rng(12,12), '0, rng(11,12), rng(11,12), '0, 13, 0, 14, 0};
`ifdef PULSE_TO_HOLD_RETRIGGER_EN
    v[nv++] = '{"retrigger", rng(10,10) | rng(13,13), '0, '0, rng(11,17), rng(11,19), '0, 14, 0, 17, 0};
`else
    v[nv++] = '{"back2back", rng(10,10) | rng(12,12), '0, '0, rng(11,14) | rng(17,20), rng(11,22), '0, 13, 1, 18, 0};
    v[nv++] = '{"saturate", rng(10,15), '0, rng(14,14) | rng(40,40),
                rng(11,14) | rng(17,20) | rng(23,26) | rng(29,32), rng(11,34), rng(15,40), 14, 3, 17, 2};
`endif
    for (int s = 0; s < nv; s++) begin
      for (int c = 0; c < 48; c++) begin
        @(negedge clock);
        if (c >= 1) begin
          chk({v[s].name, ".hold"}, c, 32'(bus.hold), 32'(v[s].hold[c]));
          chk({v[s].name, ".busy"}, c, 32'(bus.busy), 32'(v[s].busy[c]));
          chk({v[s].name, ".overflow"}, c, 32'(bus.overflow), 32'(v[s].ovf[c]));
          if (c == v[s].pc0) chk({v[s].name, ".pending"}, c, 32'(bus.pending), 32'(v[s].pv0));
          if (c == v[s].pc1) chk({v[s].name, ".pending"}, c, 32'(bus.pending), 32'(v[s].pv1));
          if (!v[s].busy[c]) chk({v[s].name, ".pending_idle"}, c, 32'(bus.pending), 32'd0);
        end
        reset = (c == 0) || v[s].rst[c];
        bus.pulse = v[s].pul[c];
        bus.clear_overflow = v[s].clr[c];
      end
    end
    @(negedge clock);
    reset = 1'b1;
    bus.pulse = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.pulse = 1'b0;
    chk("reset_vs_pulse.hold", 0, 32'(bus.hold), 32'd0);
    chk("reset_vs_pulse.busy", 0, 32'(bus.busy), 32'd0);
    bus.pulse = 1'b1;
    @(negedge clock);
    bus.pulse = 1'b0;
    chk("after_reset_pulse.hold", 1, 32'(bus.hold), 32'd1);
    chk("after_reset_pulse.busy", 1, 32'(bus.busy), 32'd1);
    chk("after_reset_pulse.pending", 1, 32'(bus.pending), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_to_hold.md
Name: pulse_to_hold

Overview:
- Inverse of the level-to-pulse edge detector. Converts single-cycle event pulses into held levels of fixed duration.
- Used to drive LEDs, buzzer enables and module-solved/strike indicators that need a visible or audible level rather than a one-clock strobe.
- Pulses that arrive while an output is in progress are counted and replayed as separate hold periods. Each hold period is separated from the next by a low gap, so the downstream edge detector sees one rising edge per input pulse.

Parameters:
- HOLD_CYCLES, 4, number of cycles hold stays high per event; must be >= 1.
- GAP_CYCLES, 2, number of low cycles between back-to-back hold periods; must be >= 1.
- CNT_WIDTH, 24, width of the shared hold/gap down-counter; must hold max(HOLD_CYCLES, GAP_CYCLES) - 1.
- PEND_WIDTH, 2, width of the pending-event counter; saturates at 2^PEND_WIDTH - 1.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- pulse, input, 1, event strobe; every cycle it is high counts as one event.
- clear_overflow, input, 1, synchronous clear of the overflow flag.
- hold, output, 1, registered held level.
- busy, output, 1, high whenever the state is not IDLE.
- pending, output, PEND_WIDTH, number of queued events not yet played.
- overflow, output, 1, sticky flag; set when an event is dropped because pending is saturated.

Behaviour:
- Reset (synchronous, reset high at a clock edge):
  - state = IDLE; hold = 0; busy = 0; pending = 0; overflow = 0; counter = 0.
  - Reset overrides all other inputs, including a pulse in the same cycle.
  - Reset mid-HOLD drops hold on the following edge. Queued events are discarded.
- States: IDLE, HOLD, GAP.
- IDLE:
  - pulse = 1 -> next cycle state = HOLD, hold = 1, counter = HOLD_CYCLES - 1.
  - Latency is 1 cycle from pulse to hold.
- HOLD:
  - hold = 1 and the counter decrements each cycle.
  - When counter == 0: next state = GAP, hold = 0, counter = GAP_CYCLES - 1.
  - hold is high for exactly HOLD_CYCLES consecutive cycles.
- GAP:
  - hold = 0 and the counter decrements each cycle.
  - When counter == 0 and pending > 0 (after this cycle's increment): next state = HOLD, hold = 1, counter = HOLD_CYCLES - 1, pending decremented.
  - When counter == 0 and pending == 0: next state = IDLE.
- Gap-after-last-event rule: GAP is always entered after HOLD, even when nothing is queued. A new pulse is therefore never rendered until at least GAP_CYCLES low cycles have passed.
- Queuing:
  - A pulse in HOLD or GAP increments pending.
  - If pending is already at its maximum, pending stays at max and overflow is set on the next cycle.
- Simultaneous increment and decrement: a pulse on the last GAP cycle with pending > 0 leaves pending unchanged. A pulse on the last GAP cycle with pending == 0 starts a new HOLD directly, with pending staying 0.
- pending is always 0 in IDLE.
- overflow:
  - Cleared by reset or by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- busy is registered and equal to (next state != IDLE). busy rises in the same cycle as hold and falls in the cycle IDLE is entered.
- Counter arithmetic is unsigned modulo 2^CNT_WIDTH. It never decrements below 0 because every reload is performed at counter == 0.

Optional Feature:
- Macro: PULSE_TO_HOLD_RETRIGGER_EN.
- Defined: a pulse during HOLD reloads counter = HOLD_CYCLES - 1, stretching the current hold. It does not increment pending. Pulses during GAP still queue.
- Undefined: pulses during HOLD queue, as described under Behaviour.

Test Plan:
- Single event: reset, then pulse at cycle 10 -> hold high cycles 11-14, low from 15; busy low at cycle 17; pending stays 0.
- Back-to-back: pulses at cycles 10 and 12 -> pending = 1 at cycle 13; hold high 11-14, low 15-16, high 17-20; busy low at cycle 23.
- Saturation: pulses at cycles 10 through 15 (PEND_WIDTH = 2) -> pending reaches 3 and holds; overflow = 1 from cycle 15; exactly 4 hold periods emitted; clear_overflow at cycle 40 -> overflow = 0 at cycle 41.
- Last-gap coincidence: pulse on the final GAP cycle with pending == 0 -> hold rises on the next cycle; pending stays 0; no IDLE cycle between.
- Reset mid-hold: pulse at cycle 10, then reset at cycle 12 together with a pulse -> hold = 0, pending = 0, state IDLE at cycle 13; no further hold.
- RETRIGGER_EN defined: pulses at cycles 10 and 13 -> hold high cycles 11-17 continuously; pending stays 0; busy low at cycle 20.
